// File: rtl/fu_cluster_pkg.sv
// Shared types for the execute cluster: issue, completion,
// memory request/response, ALU operand bundles and memq entries.
package fu_cluster_pkg;

  localparam int XLEN   = 32;
  localparam int ROB_W  = 4;
  localparam int AREG_W = 5;
  localparam int PREG_W = 6;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

  typedef struct packed {
    logic    RegWrite;
    logic    MemRead;
    logic    MemWrite;
    logic    ALUSrc;
    alu_op_e ALUOp;
  } ctrlStruct;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  robNum;
    logic [XLEN-1:0]   pc;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    ctrlStruct         control;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
  } rsIssue;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  robNum;
    logic [XLEN-1:0]   pc;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    ctrlStruct         control;
    logic [XLEN-1:0]   result;
  } completeStruct;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wr_data;
    logic            MemRead;
    logic            MemWrite;
  } memReqStruct;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rd_data;
  } memRespStruct;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_e         op;
  } aluInStruct;

  typedef struct packed {
    logic [XLEN-1:0] result;
  } aluOutStruct;

  typedef struct packed {
    logic [ROB_W-1:0]  robNum;
    logic [XLEN-1:0]   pc;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    ctrlStruct         control;
    logic [XLEN-1:0]   rs2;
    logic              is_load;
    logic              done;
    logic [XLEN-1:0]   result;
  } memqEntryStruct;

endpackage

// File: rtl/fu_cluster_alu.sv
// Combinational integer ALU used by every lane and for address
// generation. Ports: in (operands + op), out (result).
module alu
  import fu_cluster_pkg::*;
(
  input  aluInStruct  in,
  output aluOutStruct out
);

  always_comb begin
    out = '0;
    unique case (in.op)
      ALU_ADD: out.result = in.a + in.b;
      ALU_SUB: out.result = in.a - in.b;
      ALU_AND: out.result = in.a & in.b;
      ALU_OR:  out.result = in.a | in.b;
      ALU_XOR: out.result = in.a ^ in.b;
      ALU_SLT: out.result = {{(XLEN-1){1'b0}},
                 $signed(in.a) < $signed(in.b)};
      ALU_SLL: out.result = in.a << in.b[4:0];
      ALU_SRL: out.result = in.a >> in.b[4:0];
      default: out.result = '0;
    endcase
  end

endmodule

// File: rtl/fu_cluster_memq.sv
// In-order memory-lane metadata queue with load-data update port.
// Ports: clk, rst_n, clr, push/push_entry, pop, upd/upd_data,
// upd_hit, head, head_valid, full, count.
module fu_memq
  import fu_cluster_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            push,
  input  memqEntryStruct  push_entry,
  input  logic            pop,
  input  logic            upd,
  input  logic [XLEN-1:0] upd_data,
  output logic            upd_hit,
  output memqEntryStruct  head,
  output logic            head_valid,
  output logic            full,
  output logic [CW-1:0]   count
);

  memqEntryStruct q [DEPTH];
  logic [PW-1:0]  hd;
  logic [PW-1:0]  tl;
  logic [PW-1:0]  idx;
  logic [PW-1:0]  hit_idx;

  // Oldest load still waiting for data, scanning from the head.
  always_comb begin
    upd_hit = 1'b0;
    hit_idx = hd;
    idx     = hd;
    for (int i = 0; i < DEPTH; i++) begin
      idx = hd + PW'(i);
      if (!upd_hit && (CW'(i) < count) &&
          q[idx].is_load && !q[idx].done) begin
        upd_hit = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign head       = q[hd];
  assign head_valid = (count != '0);
  assign full       = (count == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else if (clr) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q[tl] <= push_entry;
        tl    <= tl + PW'(1);
      end
      if (pop)
        hd <= hd + PW'(1);
      if (upd && upd_hit) begin
        q[hit_idx].done   <= 1'b1;
        q[hit_idx].result <= upd_data;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fu_cluster.sv
// Execute cluster: NUM_ALU registered ALU lanes plus one in-order
// memory lane. Ports: alu_issue/alu_complete per lane; mem_issue,
// mem_issue_ready, request/req_ready, response, mem_complete,
// memq_count; flush only when FU_FLUSH_EN is defined.
module fu_cluster
  import fu_cluster_pkg::*;
#(
  parameter  int NUM_ALU    = 2,
  parameter  int MEMQ_DEPTH = 4,
  localparam int CW = $clog2(MEMQ_DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  rsIssue        alu_issue    [NUM_ALU],
  output completeStruct alu_complete [NUM_ALU],
  input  rsIssue        mem_issue,
  output logic          mem_issue_ready,
  output memReqStruct   request,
  input  logic          req_ready,
  input  memRespStruct  response,
  output completeStruct mem_complete,
  output logic [CW-1:0] memq_count
`ifdef FU_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  logic flush_i;
  logic drop_active;

  for (genvar i = 0; i < NUM_ALU; i++) begin : g_lane
    aluInStruct  ain;
    aluOutStruct aout;

    assign ain.a  = alu_issue[i].rs1;
    assign ain.b  = alu_issue[i].control.ALUSrc ?
                    alu_issue[i].imm : alu_issue[i].rs2;
    assign ain.op = alu_issue[i].control.ALUOp;

    alu u_alu (.in(ain), .out(aout));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush_i) begin
        alu_complete[i] <= '0;
      end else begin
        alu_complete[i].valid   <= alu_issue[i].valid;
        alu_complete[i].robNum  <= alu_issue[i].robNum;
        alu_complete[i].pc      <= alu_issue[i].pc;
        alu_complete[i].rd      <= alu_issue[i].rd;
        alu_complete[i].rd_old  <= alu_issue[i].rd_old;
        alu_complete[i].control <= alu_issue[i].control;
        alu_complete[i].result  <= aout.result;
      end
    end
  end

  aluInStruct  agen_in;
  aluOutStruct agen_out;

  assign agen_in.a  = mem_issue.rs1;
  assign agen_in.b  = mem_issue.imm;
  assign agen_in.op = ALU_ADD;

  alu u_agen (.in(agen_in), .out(agen_out));

  logic           full;
  logic           head_valid;
  logic           upd_hit;
  memqEntryStruct head;
  memqEntryStruct new_entry;
  logic           accept;
  logic           is_load;
  logic           pop;
  logic           resp_use;
  logic           hs;

  // A stalled request blocks new issue so its fields stay put.
  assign mem_issue_ready = !full && !(request.valid && !req_ready);
  assign accept   = mem_issue.valid && mem_issue_ready && !flush_i;
  assign is_load  = mem_issue.control.MemRead;
  assign pop      = head_valid && head.done && !flush_i;
  assign resp_use = response.valid && !drop_active && !flush_i;
  assign hs       = request.valid && req_ready;

  always_comb begin
    new_entry         = '0;
    new_entry.robNum  = mem_issue.robNum;
    new_entry.pc      = mem_issue.pc;
    new_entry.rd      = mem_issue.rd;
    new_entry.rd_old  = mem_issue.rd_old;
    new_entry.control = mem_issue.control;
    new_entry.rs2     = mem_issue.rs2;
    new_entry.is_load = is_load;
    new_entry.done    = !is_load;
    new_entry.result  = mem_issue.rs2;
  end

  fu_memq #(.DEPTH(MEMQ_DEPTH)) u_memq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (flush_i),
    .push       (accept),
    .push_entry (new_entry),
    .pop        (pop),
    .upd        (resp_use),
    .upd_data   (response.rd_data),
    .upd_hit    (upd_hit),
    .head       (head),
    .head_valid (head_valid),
    .full       (full),
    .count      (memq_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      request <= '0;
    end else if (flush_i) begin
      request.valid <= 1'b0;
    end else if (accept && is_load) begin
      request.valid    <= 1'b1;
      request.addr     <= agen_out.result;
      request.wr_data  <= mem_issue.rs2;
      request.MemRead  <= 1'b1;
      request.MemWrite <= 1'b0;
    end else if (req_ready) begin
      request.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_complete <= '0;
    end else if (pop) begin
      mem_complete.valid   <= 1'b1;
      mem_complete.robNum  <= head.robNum;
      mem_complete.pc      <= head.pc;
      mem_complete.rd      <= head.rd;
      mem_complete.rd_old  <= head.rd_old;
      mem_complete.control <= head.control;
      mem_complete.result  <= head.is_load ?
                              head.result : head.rs2;
    end else begin
      mem_complete <= '0;
    end
  end

`ifdef FU_FLUSH_EN
  logic [7:0] inflight;
  logic [7:0] drop_cnt;
  logic       resp_cnt;

  assign flush_i     = flush;
  assign drop_active = (drop_cnt != '0);
  assign resp_cnt    = response.valid && (inflight != '0);

  // Requests already on the bus at flush time still answer;
  // remember how many so their data is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + 8'(hs) - 8'(resp_cnt);
      if (flush_i)
        drop_cnt <= inflight + 8'(hs) - 8'(resp_cnt);
      else if (response.valid && drop_active)
        drop_cnt <= drop_cnt - 8'd1;
    end
  end
`else
  assign flush_i     = 1'b0;
  assign drop_active = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n && resp_use)
      assert (upd_hit)
      else $warning("fu_cluster: response without pending load ignored");
  end

endmodule

// File: doc/fu_cluster.md
# fu_cluster

Parametrised execute cluster: NUM_ALU combinational ALU lanes with registered completion, plus one memory lane with an in-order metadata queue that tracks up to MEMQ_DEPTH outstanding load/store ops, a ready/valid request handshake toward memory, and in-order completion. Sits between the reservation-station issue ports and the ROB/CDB completion ports. Supersedes the fixed two-ALU, one-memory-lane FU block: adds lane count, backpressure, multiple outstanding loads and reset.

## Interface
- NUM_ALU, 2: number of ALU lanes (1..4).
- MEMQ_DEPTH, 4: memory-lane queue entries (power of two, ≥2).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_issue  in  rsIssue[NUM_ALU]  per-lane issue.
- alu_complete  out  completeStruct[NUM_ALU]  per-lane completion.
- mem_issue  in  rsIssue  memory-lane issue.
- mem_issue_ready  out  1  memory lane accepts mem_issue this cycle.
- request  out  memReqStruct  load request to memory.
- req_ready  in  1  memory accepts request this cycle.
- response  in  memRespStruct  load data; responses return in request order.
- mem_complete  out  completeStruct  memory-lane completion.
- memq_count  out  $clog2(MEMQ_DEPTH+1)  occupied queue entries.
- flush  in  1  squash all in-flight work (present only with FU_FLUSH_EN).

## Operation
- ALU lane i: alu sub-instance computes from alu_issue[i]; alu_complete[i] registers valid, robNum, pc, rd, rd_old, control, result every cycle.
- Mem accept: mem_issue.valid && mem_issue_ready. mem_issue_ready = !full && !(request.valid && !req_ready).
- On accept: push entry {robNum, pc, rd, rd_old, control, rs2, is_load=control.MemRead, done=!is_load, result=rs2}. Address = rs1+imm via alu instance.
- Load accept: request loads {addr, wr_data=rs2, MemRead=1, MemWrite=0, valid=1}. Store: no request; stores write memory at commit.
- request.valid holds, fields stable, until req_ready; then clears unless reloaded same edge.
- response.valid: rd_data written to oldest entry with is_load && !done (priority scan from head); done set. response.valid with no such entry: ignored, assertion fires.
- Retire: head.done → pop; mem_complete gets entry fields, valid=1, result = load data or store rs2. At most one retire per cycle; push and pop may coincide.
- memq_count = entries occupied; full at MEMQ_DEPTH; pointers wrap modulo MEMQ_DEPTH.

## Timing
- Reset: every output field 0, queue empty, memq_count 0, mem_issue_ready 1.
- ALU: issue edge k → alu_complete valid at edge k+1; no backpressure.
- Store: accept edge k → mem_complete valid edge k+1 if queue was empty.
- Load: accept edge k → request.valid edge k+1; response sampled edge r → mem_complete valid edge r+1 if head.
- Response and retire of a different entry in the same cycle: both occur.
- Reset mid-operation: all state cleared immediately; later responses ignored.

## Configuration
- FU_FLUSH_EN defined: flush port exists. flush at edge k clears queue, request.valid, all completion valids at k+1; mem_issue ignored that cycle. A counter of requests sent but unanswered is captured; that many subsequent responses are dropped. Flush has priority over accept, response, retire.
- Undefined: no flush port, no drop counter; squash handled by ROB.

## Structure
- typedefs package: rsIssue, completeStruct, memReqStruct, memRespStruct, aluInStruct, aluOutStruct, new memqEntryStruct.
- Existing alu module per lane and for address generation.
- One sub-module: fu_memq (circular queue with done/result update port and oldest-pending-load scan).

## Test plan
- ALU: lane0 ADD 5+7, lane1 SUB 9-4 at edge k → alu_complete results 12 and 5, valid at k+1.
- Load rs1=0x100, imm=8, req_ready=1 → request.addr 0x108, MemRead 1; response 0xDEAD 3 cycles later → mem_complete.result 0xDEAD next edge.
- Store rs2=0x55 behind pending load → no request; mem_complete order load then store, store result 0x55.
- req_ready=0 held 3 cycles, load pending → request stable, mem_issue_ready 0; 4 loads fill queue → memq_count 4, ready 0.
- Flush (FU_FLUSH_EN) with 2 loads requested → next two responses dropped, no mem_complete; new load then completes normally.
- rst_n low mid-load → all outputs 0 asynchronously; stale response after release produces nothing.
